// File: rtl/alu_mul_seq_if.sv
// Bus between the multiply sequencer and its surroundings: the control-unit
// request/response handshake plus the shared 8-bit ALU operand/result lines.
interface alu_mul_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OP_W  = 4
);
  // Request / response with the control unit
  logic                 start;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  // Shared ALU bus
  logic [OP_W-1:0]      alu_op;
  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [WIDTH-1:0]     alu_out;
  logic                 alu_carry;

  // Sequencer side
  modport slave (
    input  start, op_a, op_b, alu_out, alu_carry,
    output busy, done, product, alu_op, alu_a, alu_b
  );

  // Control unit + ALU side
  modport master (
    output start, op_a, op_b, alu_out, alu_carry,
    input  busy, done, product, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the shared combinational ALU.
// Each of the 8 iterations optionally adds the multiplicand into the high
// byte, then shifts {cy, acc_hi, mq} right one bit using two ALU shifts.
// All ALU bus outputs are registered and set on the edge entering a state.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OP_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_mul_seq_if.slave  bus
);

  // ALU opcodes used by this block
  localparam logic [OP_W-1:0] kPASS_A      = OP_W'(0);
  localparam logic [OP_W-1:0] kADD         = OP_W'(1);
  localparam logic [OP_W-1:0] kSHIFT_RIGHT = OP_W'(5);
  localparam logic [OP_W-1:0] kA_IS_ZERO   = OP_W'(9);

  typedef enum logic [2:0] {
    StIdle,
    StZchk,
    StAdd,
    StShrHi,
    StShrLo,
    StDone
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     acc_hi_q;
  logic [WIDTH-1:0]     mq_q;
  logic                 cy_q;
  logic                 lsb_sv_q;
  logic [2:0]           cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [OP_W-1:0]      alu_op_q;
  logic [WIDTH-1:0]     alu_a_q;
  logic [WIDTH-1:0]     alu_b_q;

  logic                 add_cy;
  logic [WIDTH-1:0]     shr_hi;
  logic [WIDTH-1:0]     mq_next;

  // ALU CarryOut is not valid for kADD, so the carry is recovered from wrap-around
  assign add_cy  = (bus.alu_out < acc_hi_q);
  assign shr_hi  = {cy_q, bus.alu_out[WIDTH-2:0]};
  assign mq_next = {lsb_sv_q, bus.alu_out[WIDTH-2:0]};

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.alu_op  = alu_op_q;
  assign bus.alu_a   = alu_a_q;
  assign bus.alu_b   = alu_b_q;

  // Sequencer FSM: state, datapath registers and registered ALU/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      mq_q      <= '0;
      cy_q      <= 1'b0;
      lsb_sv_q  <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      alu_op_q  <= kPASS_A;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            mcand_q  <= bus.op_a;
            mq_q     <= bus.op_b;
            acc_hi_q <= '0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            alu_op_q <= kA_IS_ZERO;
            alu_a_q  <= bus.op_a;
            alu_b_q  <= '0;
            state_q  <= StZchk;
          end
        end
        StZchk: begin
          if (bus.alu_carry) begin
            // Zero multiplicand: skip the loop entirely
            product_q <= '0;
            done_q    <= 1'b1;
            alu_op_q  <= kPASS_A;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            state_q   <= StDone;
          end else if (mq_q[0]) begin
            alu_op_q <= kADD;
            alu_a_q  <= acc_hi_q;
            alu_b_q  <= mcand_q;
            state_q  <= StAdd;
          end else begin
            alu_op_q <= kSHIFT_RIGHT;
            alu_a_q  <= acc_hi_q;
            alu_b_q  <= '0;
            state_q  <= StShrHi;
          end
        end
        StAdd: begin
          acc_hi_q <= bus.alu_out;
          cy_q     <= add_cy;
          alu_op_q <= kSHIFT_RIGHT;
          alu_a_q  <= bus.alu_out;
          alu_b_q  <= '0;
          state_q  <= StShrHi;
        end
        StShrHi: begin
          acc_hi_q <= shr_hi;
          lsb_sv_q <= acc_hi_q[0];
          cy_q     <= 1'b0;
          alu_op_q <= kSHIFT_RIGHT;
          alu_a_q  <= mq_q;
          alu_b_q  <= '0;
          state_q  <= StShrLo;
        end
        StShrLo: begin
          mq_q <= mq_next;
          if (cnt_q == 3'd7) begin
            product_q <= {acc_hi_q, mq_next};
            done_q    <= 1'b1;
            alu_op_q  <= kPASS_A;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            state_q   <= StDone;
          end else begin
            cnt_q   <= cnt_q + 3'd1;
            alu_a_q <= acc_hi_q;
            if (mq_next[0]) begin
              alu_op_q <= kADD;
              alu_b_q  <= mcand_q;
              state_q  <= StAdd;
            end else begin
              alu_op_q <= kSHIFT_RIGHT;
              alu_b_q  <= '0;
              state_q  <= StShrHi;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q   <= 1'b0;
          alu_op_q <= kPASS_A;
          alu_a_q  <= '0;
          alu_b_q  <= '0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule
